// File: rtl/status_register_unit.sv
// status_register_unit
//   Producer side of the NZCV condition-flag interface. Derives N/Z from the
//   EXE-stage ALU result, takes C/V from the ALU, and holds the architectural
//   NZCV register {N,Z,C,V} = [3:0]. A small LIFO saves and restores flags
//   around exception entry and return.
//
//   Build option: define STATUS_FLAG_BYPASS_EN to make flags_fwd the
//   combinational next-state NZCV. When it is undefined, flags_fwd is the
//   registered flags_out. The port list is the same in both builds.
//
//   Strobe semantics: save_req, restore_req and err_clr are single-cycle
//   requests. Each is sampled on every rising edge at which it is high. There
//   is no ready/backpressure. A request the LIFO cannot honour is dropped and
//   recorded in the sticky stack_err.
module status_register_unit #(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              s_en,
  input  logic              stall,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              err_clr,
  output logic [3:0]        flags_out,
  output logic [3:0]        flags_fwd,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Architectural state
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;
  logic [3:0]       stack_mem [STACK_DEPTH];

  // Next-state and decode signals
  logic             upd;
  logic [3:0]       alu_flags;
  logic             save_only;
  logic             restore_only;
  logic             illegal_req;
  logic             do_push;
  logic             do_pop;
  logic             err_evt;
  logic [CNT_W-1:0] count_m1;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] top_idx;
  logic [3:0]       flags_next;
  logic [CNT_W-1:0] count_next;
  logic             err_next;
  logic             full_int;
  logic             empty_int;

  // Occupancy decoded straight from the count register.
  assign full_int  = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_int = (count_q == '0);

  // Decode the ALU update and the stack request.
  always_comb begin
    upd          = ex_valid & s_en & ~stall;
    alu_flags    = {alu_result[DATA_W-1], (alu_result == '0), alu_c, alu_v};
    save_only    = save_req & ~restore_req;
    restore_only = restore_req & ~save_req;
    illegal_req  = save_req & restore_req;
    do_push      = save_only & ~full_int;
    do_pop       = restore_only & ~empty_int;
    err_evt      = illegal_req
                 | (save_only & full_int)
                 | (restore_only & empty_int);
    count_m1     = count_q - CNT_W'(1);
    // When a push is allowed the count is below STACK_DEPTH, so its low bits
    // index the next free slot. When a pop is allowed count-1 is the top entry.
    push_idx     = count_q[PTR_W-1:0];
    top_idx      = count_m1[PTR_W-1:0];
  end

  // Next-state NZCV. A successful pop overrides the ALU update in that cycle.
  always_comb begin
    flags_next = flags_q;
    if (do_pop) begin
      flags_next = stack_mem[top_idx];
    end else if (upd) begin
      flags_next = alu_flags;
    end
  end

  // Next-state entry count and sticky error. A new error beats err_clr.
  always_comb begin
    count_next = count_q;
    if (do_push) begin
      count_next = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_next = count_m1;
    end
    err_next = err_q;
    if (err_evt) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  // Flag register, entry count and sticky error, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_next;
      count_q <= count_next;
      err_q   <= err_next;
    end
  end

  // LIFO storage. Contents are don't-care after reset, so it has no reset.
  // The pushed value is the registered flags, not the value being updated.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[push_idx] <= flags_q;
    end
  end

  assign flags_out   = flags_q;
  assign stack_empty = empty_int;
  assign stack_full  = full_int;
  assign stack_err   = err_q;

`ifdef STATUS_FLAG_BYPASS_EN
  // Same-cycle consumers see the flags that will be registered at this edge.
  assign flags_fwd = flags_next;
`else
  // Consumers see the registered flags. The hazard unit covers the gap.
  assign flags_fwd = flags_q;
`endif

`ifndef SYNTHESIS
  // The count never exceeds the LIFO depth.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CNT_W'(STACK_DEPTH))
        else $error("status_register_unit: count out of range");
      assert (!(full_int && empty_int))
        else $error("status_register_unit: full and empty together");
    end
  end
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Testbench for status_register_unit with DATA_W=32 and STACK_DEPTH=4.
// A table of {inputs, expected outputs} is applied one vector per clock.
// Expected outputs are queued when a vector is driven and checked after the
// edge. Two hand-written sequences follow: an asynchronous reset taken with
// count=3, and recovery from that reset.
module tb_status_register_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              ex_valid;
  logic              s_en;
  logic              stall;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_v;
  logic              save_req;
  logic              restore_req;
  logic              err_clr;
  logic [3:0]        flags_out;
  logic [3:0]        flags_fwd;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  status_register_unit #(
    .DATA_W     (DATA_W),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .s_en       (s_en),
    .stall      (stall),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .save_req   (save_req),
    .restore_req(restore_req),
    .err_clr    (err_clr),
    .flags_out  (flags_out),
    .flags_fwd  (flags_fwd),
    .stack_empty(stack_empty),
    .stack_full (stack_full),
    .stack_err  (stack_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic              ev;
    logic              s;
    logic              st;
    logic [DATA_W-1:0] res;
    logic              c;
    logic              v;
    logic              sv;
    logic              rs;
    logic              clr;
    logic [3:0]        fl;
    logic              emp;
    logic              full;
    logic              err;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];   // {flags, empty, full, err}
  logic [3:0] last_flags; // flags_out expected before the current vector
  int         n_cmp;
  int         n_fail;

  function automatic vec_t mk(logic ev, logic s, logic st, logic [DATA_W-1:0] res,
                              logic c, logic v, logic sv, logic rs, logic clr,
                              logic [3:0] fl, logic emp, logic full, logic err);
    vec_t t;
    t.ev = ev; t.s = s; t.st = st; t.res = res; t.c = c; t.v = v;
    t.sv = sv; t.rs = rs; t.clr = clr;
    t.fl = fl; t.emp = emp; t.full = full; t.err = err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ex_valid = 1'b0; s_en = 1'b0; stall = 1'b0; alu_result = '0;
    alu_c = 1'b0; alu_v = 1'b0; save_req = 1'b0; restore_req = 1'b0; err_clr = 1'b0;
  endtask

  // Drive one vector shortly after a rising edge, check the same-cycle
  // forward value, then check the registered outputs after the next edge.
  task automatic apply(input vec_t t, input int idx);
    logic [6:0] e;
    ex_valid = t.ev; s_en = t.s; stall = t.st; alu_result = t.res;
    alu_c = t.c; alu_v = t.v; save_req = t.sv; restore_req = t.rs; err_clr = t.clr;
    exp_q.push_back({t.fl, t.emp, t.full, t.err});
    #1;
`ifdef STATUS_FLAG_BYPASS_EN
    check($sformatf("v%0d flags_fwd", idx), 32'(flags_fwd), 32'(t.fl));
`else
    check($sformatf("v%0d flags_fwd", idx), 32'(flags_fwd), 32'(last_flags));
`endif
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d scoreboard: got empty queue want 1 entry", idx);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d flags_out", idx),   32'(flags_out),   32'(e[6:3]));
      check($sformatf("v%0d stack_empty", idx), 32'(stack_empty), 32'(e[2]));
      check($sformatf("v%0d stack_full", idx),  32'(stack_full),  32'(e[1]));
      check($sformatf("v%0d stack_err", idx),   32'(stack_err),   32'(e[0]));
    end
    last_flags = t.fl;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " flags_out"},   32'(flags_out),   32'h0);
    check({tag, " flags_fwd"},   32'(flags_fwd),   32'h0);
    check({tag, " stack_empty"}, 32'(stack_empty), 32'h1);
    check({tag, " stack_full"},  32'(stack_full),  32'h0);
    check({tag, " stack_err"},   32'(stack_err),   32'h0);
  endtask

  // ---------------- test ----------------
  localparam logic [31:0] NEG = 32'h8000_0000;
  localparam logic [31:0] ONE = 32'h0000_0001;
  localparam logic [31:0] ZER = 32'h0000_0000;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    last_flags = 4'b0000;

    //           ev s  st res  c  v  sv rs clr  flags    emp full err
    vecs.push_back(mk(0,0,0,ZER,0,0,0,0,0, 4'b0000, 1,0,0)); // 0 idle
    vecs.push_back(mk(1,1,0,NEG,1,0,0,0,0, 4'b1010, 1,0,0)); // 1 N,C
    vecs.push_back(mk(1,1,0,ZER,0,1,0,0,0, 4'b0101, 1,0,0)); // 2 Z,V
    vecs.push_back(mk(1,1,1,NEG,1,0,0,0,0, 4'b0101, 1,0,0)); // 3 stall blocks
    vecs.push_back(mk(1,0,0,NEG,1,0,0,0,0, 4'b0101, 1,0,0)); // 4 s_en=0 blocks
    vecs.push_back(mk(0,1,0,NEG,1,0,0,0,0, 4'b0101, 1,0,0)); // 5 ex_valid=0 blocks
    vecs.push_back(mk(1,1,0,NEG,1,0,0,0,0, 4'b1010, 1,0,0)); // 6 flags=1010
    vecs.push_back(mk(1,1,0,ZER,0,0,1,0,0, 4'b0100, 0,0,0)); // 7 save 1010, ALU->0100
    vecs.push_back(mk(1,1,0,NEG,1,1,0,1,0, 4'b1010, 1,0,0)); // 8 restore beats ALU
    vecs.push_back(mk(1,1,0,ONE,1,0,0,0,0, 4'b0010, 1,0,0)); // 9
    vecs.push_back(mk(1,1,0,ZER,0,0,1,0,0, 4'b0100, 0,0,0)); // 10 push 0010
    vecs.push_back(mk(1,1,0,NEG,0,1,1,0,0, 4'b1001, 0,0,0)); // 11 push 0100
    vecs.push_back(mk(1,1,0,ZER,1,1,1,0,0, 4'b0111, 0,0,0)); // 12 push 1001
    vecs.push_back(mk(1,1,0,ONE,1,1,1,0,0, 4'b0011, 0,1,0)); // 13 push 0111 -> full
    vecs.push_back(mk(1,1,0,ONE,0,0,1,0,0, 4'b0000, 0,1,1)); // 14 save while full
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0111, 0,0,1)); // 15 pop
    vecs.push_back(mk(1,1,0,ZER,0,0,0,1,0, 4'b1001, 0,0,1)); // 16 pop beats ALU
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0100, 0,0,1)); // 17 pop
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0010, 1,0,1)); // 18 pop -> empty
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0010, 1,0,1)); // 19 restore while empty
    vecs.push_back(mk(1,1,0,NEG,0,0,0,1,0, 4'b1000, 1,0,1)); // 20 empty restore, ALU applies
    vecs.push_back(mk(0,0,0,ZER,0,0,0,0,1, 4'b1000, 1,0,0)); // 21 err_clr
    vecs.push_back(mk(0,0,0,ZER,0,0,0,0,0, 4'b1000, 1,0,0)); // 22 idle
    vecs.push_back(mk(1,1,0,ZER,0,0,1,1,1, 4'b0100, 1,0,1)); // 23 illegal beats err_clr
    vecs.push_back(mk(0,0,0,ZER,0,0,0,0,1, 4'b0100, 1,0,0)); // 24 err_clr
    vecs.push_back(mk(0,0,0,ZER,0,0,1,0,0, 4'b0100, 0,0,0)); // 25 push 0100
    vecs.push_back(mk(1,1,0,ONE,1,0,1,0,0, 4'b0010, 0,0,0)); // 26 push 0100, count=2
    vecs.push_back(mk(1,1,0,NEG,1,1,1,1,0, 4'b1011, 0,0,1)); // 27 illegal, ALU applies
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0100, 0,0,1)); // 28 pop (count was 2)
    vecs.push_back(mk(0,0,0,ZER,0,0,0,1,0, 4'b0100, 1,0,1)); // 29 pop -> empty
    vecs.push_back(mk(0,0,0,ZER,0,0,0,0,1, 4'b0100, 1,0,0)); // 30 err_clr
    vecs.push_back(mk(1,1,0,NEG,0,0,0,0,0, 4'b1000, 1,0,0)); // 31
    vecs.push_back(mk(1,1,1,ZER,1,0,1,0,0, 4'b1000, 0,0,0)); // 32 save under stall
    vecs.push_back(mk(1,1,0,ZER,0,1,0,0,0, 4'b0101, 0,0,0)); // 33
    vecs.push_back(mk(0,0,1,ZER,0,0,0,1,0, 4'b1000, 1,0,0)); // 34 restore under stall
    vecs.push_back(mk(1,1,0,NEG,0,0,1,0,0, 4'b1000, 0,0,0)); // 35 push 1000, c=1
    vecs.push_back(mk(1,1,0,ONE,0,1,1,0,0, 4'b0001, 0,0,0)); // 36 push 1000, c=2
    vecs.push_back(mk(0,0,0,ZER,0,0,1,0,0, 4'b0001, 0,0,0)); // 37 push 0001, c=3
    vecs.push_back(mk(0,0,0,ZER,0,0,1,1,0, 4'b0001, 0,0,1)); // 38 illegal sets err, c=3

    // Reset held from time 0, checked while asserted and after release.
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("after reset");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Mid-operation reset with count=3, stack_err=1 and a pending save.
    #3;
    save_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_state("async reset");
    @(posedge clk);
    #1;
    check_reset_state("reset held mid");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    last_flags = 4'b0000;
    // Count must be 0: a restore now underflows and leaves flags unchanged.
    apply(mk(0,0,0,ZER,0,0,0,1,0, 4'b0000, 1,0,1), 100);
    apply(mk(0,0,0,ZER,0,0,0,0,1, 4'b0000, 1,0,0), 101);

    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
